// File: rtl/router_nport_fifo.sv
// 1-to-N word router: each input word is steered by addr into a per-output FIFO.
// Every output drains first-word-fall-through under its own valid/ready handshake.
module router_nport_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_WIDTH-1:0]                     din,
  input  logic [ADDR_WIDTH-1:0]                     addr,
  input  logic                                      valid_in,
  output logic                                      ready_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]           dout,
  output logic [NUM_PORTS-1:0]                      valid_out,
  input  logic [NUM_PORTS-1:0]                      ready_in,
  output logic [NUM_PORTS*($clog2(FIFO_DEPTH)+1)-1:0] fifo_count,
  output logic                                      drop_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_PORTS-1:0] full;
  logic                 addr_ok;
  logic                 accept;

  // Extra bit so NUM_PORTS itself is representable on the compare side.
  assign addr_ok = ({1'b0, addr} < (ADDR_WIDTH+1)'(NUM_PORTS));

  always_comb begin
    ready_out = 1'b1;
    if (addr_ok) ready_out = !full[addr];
  end

  assign accept = valid_in && ready_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_err <= 1'b0;
    else        drop_err <= valid_in && !addr_ok;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    assign push    = accept && addr_ok && (addr == ADDR_WIDTH'(p));
    assign pop     = (count != '0) && ready_in[p];
    assign full[p] = (count == CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end

    // Storage needs no reset: stale words are masked by count == 0.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
    end

    assign valid_out[p]                          = (count != '0);
    assign dout[p*DATA_WIDTH +: DATA_WIDTH]      = (count != '0) ? mem[rd_ptr] : '0;
    assign fifo_count[p*CNT_W +: CNT_W]          = count;
  end

endmodule

// File: tb/tb_router_nport_fifo.sv
// Bench for router_nport_fifo: a 4-port and a 3-port instance checked every cycle
// against queue-based per-port reference models, plus directed scenarios.
module tb_router_nport_fifo;

  localparam int W   = 8;
  localparam int NPA = 4;
  localparam int NPB = 3;
  localparam int D   = 4;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0]       din_a, din_b;
  logic [1:0]         addr_a, addr_b;
  logic               valid_a, valid_b, ready_a, ready_b;
  logic [NPA*W-1:0]   dout_a;
  logic [NPB*W-1:0]   dout_b;
  logic [NPA-1:0]     vout_a, rin_a;
  logic [NPB-1:0]     vout_b, rin_b;
  logic [NPA*CW-1:0]  cnt_a;
  logic [NPB*CW-1:0]  cnt_b;
  logic               drop_a, drop_b;

  router_nport_fifo #(.DATA_WIDTH(W), .NUM_PORTS(NPA), .FIFO_DEPTH(D)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .addr(addr_a), .valid_in(valid_a),
    .ready_out(ready_a), .dout(dout_a), .valid_out(vout_a), .ready_in(rin_a),
    .fifo_count(cnt_a), .drop_err(drop_a));

  router_nport_fifo #(.DATA_WIDTH(W), .NUM_PORTS(NPB), .FIFO_DEPTH(D)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .addr(addr_b), .valid_in(valid_b),
    .ready_out(ready_b), .dout(dout_b), .valid_out(vout_b), .ready_in(rin_b),
    .fifo_count(cnt_b), .drop_err(drop_b));

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] qa [NPA][$];
  logic [W-1:0] qb [NPB][$];
  logic [W-1:0] seen3 [$];
  logic exp_drop_a = 1'b0;
  logic exp_drop_b = 1'b0;
  logic last_acc_a = 1'b0;
  logic last_acc_b = 1'b0;
  logic rec3 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_rdy_a();
    return qa[addr_a].size() < D;
  endfunction

  function automatic logic exp_rdy_b();
    if (int'(addr_b) >= NPB) return 1'b1;
    return qb[addr_b].size() < D;
  endfunction

  task automatic check_outputs(input string ph);
    logic [NPA*W-1:0]  ed_a = '0;
    logic [NPA-1:0]    ev_a = '0;
    logic [NPA*CW-1:0] ec_a = '0;
    logic [NPB*W-1:0]  ed_b = '0;
    logic [NPB-1:0]    ev_b = '0;
    logic [NPB*CW-1:0] ec_b = '0;
    for (int i = 0; i < NPA; i++) begin
      if (qa[i].size() > 0) begin
        ed_a[i*W +: W] = qa[i][0];
        ev_a[i] = 1'b1;
      end
      ec_a[i*CW +: CW] = CW'(qa[i].size());
    end
    for (int i = 0; i < NPB; i++) begin
      if (qb[i].size() > 0) begin
        ed_b[i*W +: W] = qb[i][0];
        ev_b[i] = 1'b1;
      end
      ec_b[i*CW +: CW] = CW'(qb[i].size());
    end
    chk({ph, ":a_dout"},  64'(dout_a), 64'(ed_a));
    chk({ph, ":a_valid"}, 64'(vout_a), 64'(ev_a));
    chk({ph, ":a_count"}, 64'(cnt_a),  64'(ec_a));
    chk({ph, ":a_drop"},  64'(drop_a), 64'(exp_drop_a));
    chk({ph, ":b_dout"},  64'(dout_b), 64'(ed_b));
    chk({ph, ":b_valid"}, 64'(vout_b), 64'(ev_b));
    chk({ph, ":b_count"}, 64'(cnt_b),  64'(ec_b));
    chk({ph, ":b_drop"},  64'(drop_b), 64'(exp_drop_b));
  endtask

  // One clock: check at the falling edge, then advance the model on the rising edge.
  task automatic cycle(input string ph);
    logic acc_a, acc_b;
    logic [NPA-1:0] pop_a;
    logic [NPB-1:0] pop_b;
    @(negedge clk);
    check_outputs(ph);
    chk({ph, ":a_ready"}, 64'(ready_a), 64'(exp_rdy_a()));
    chk({ph, ":b_ready"}, 64'(ready_b), 64'(exp_rdy_b()));
    acc_a = valid_a && exp_rdy_a();
    acc_b = valid_b && exp_rdy_b();
    for (int i = 0; i < NPA; i++) pop_a[i] = (qa[i].size() > 0) && rin_a[i];
    for (int i = 0; i < NPB; i++) pop_b[i] = (qb[i].size() > 0) && rin_b[i];
    if (rec3 && vout_a[3] && rin_a[3]) seen3.push_back(dout_a[3*W +: W]);
    @(posedge clk);
    for (int i = 0; i < NPA; i++) if (pop_a[i]) void'(qa[i].pop_front());
    for (int i = 0; i < NPB; i++) if (pop_b[i]) void'(qb[i].pop_front());
    if (acc_a) qa[addr_a].push_back(din_a);
    if (acc_b && int'(addr_b) < NPB) qb[addr_b].push_back(din_b);
    exp_drop_a = acc_a && (int'(addr_a) >= NPA);
    exp_drop_b = acc_b && (int'(addr_b) >= NPB);
    last_acc_a = acc_a;
    last_acc_b = acc_b;
    #1;
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic do_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NPA; i++) qa[i].delete();
    for (int i = 0; i < NPB; i++) qb[i].delete();
    exp_drop_a = 1'b0;
    exp_drop_b = 1'b0;
    check_outputs("rst_async");
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int thr_a, thr_b;
    rst_n = 1'b0;
    din_a = '0; addr_a = '0; valid_a = 1'b0; rin_a = '1;
    din_b = '0; addr_b = '0; valid_b = 1'b0; rin_b = '1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word to port 0
    din_a = 8'hA1; addr_a = 2'd0; valid_a = 1'b1;
    cycle("t1");
    chk("t1_acc", 64'(last_acc_a), 64'd1);
    chk("t1_valid", 64'(vout_a), 64'h1);
    chk("t1_dout0", 64'(dout_a[7:0]), 64'hA1);
    valid_a = 1'b0;
    cycle("t1");
    chk("t1_valid_gone", 64'(vout_a), 64'h0);
    chk("t1_count0", 64'(cnt_a), 64'h0);

    // Backpressure isolation on port 3
    rin_a = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      din_a = 8'(8'hC0 + k); addr_a = 2'd3; valid_a = 1'b1;
      cycle("t2_fill");
      chk("t2_fill_acc", 64'(last_acc_a), 64'd1);
    end
    din_a = 8'hC4; addr_a = 2'd3;
    repeat (2) begin
      cycle("t2_stall");
      chk("t2_stall_acc", 64'(last_acc_a), 64'd0);
    end
    chk("t2_stall_rdy", 64'(ready_a), 64'd0);
    chk("t2_count3", 64'(cnt_a[3*CW +: CW]), 64'd4);
    din_a = 8'hB2; addr_a = 2'd2;
    cycle("t2_other");
    chk("t2_other_acc", 64'(last_acc_a), 64'd1);
    chk("t2_other_dout", 64'(dout_a[2*W +: W]), 64'hB2);

    // Release port 3 while its full FIFO is targeted: no push in the popping cycle
    din_a = 8'hC4; addr_a = 2'd3; rin_a = 4'b1111; rec3 = 1'b1;
    cycle("t3");
    chk("t3_full_no_push", 64'(last_acc_a), 64'd0);
    cycle("t3");
    chk("t3_push_next", 64'(last_acc_a), 64'd1);
    valid_a = 1'b0;
    repeat (6) cycle("t3_drain");
    rec3 = 1'b0;
    chk("t2_seen_len", 64'(seen3.size()), 64'd5);
    for (int k = 0; k < 5 && k < seen3.size(); k++)
      chk("t2_seen_order", 64'(seen3[k]), 64'(8'hC0 + k));

    // Steady streaming through port 2
    for (int k = 0; k < 16; k++) begin
      din_a = 8'($urandom); addr_a = 2'd2; valid_a = 1'b1;
      cycle("t4");
      chk("t4_acc", 64'(last_acc_a), 64'd1);
      chk("t4_cnt_le1", 64'(cnt_a[2*CW +: CW] <= 3'd1), 64'd1);
    end
    valid_a = 1'b0;
    repeat (2) cycle("t4_drain");

    // Out-of-range address on the 3-port instance
    din_b = 8'h55; addr_b = 2'd3; valid_b = 1'b1;
    cycle("t5");
    chk("t5_acc", 64'(last_acc_b), 64'd1);
    chk("t5_drop", 64'(drop_b), 64'd1);
    chk("t5_valid", 64'(vout_b), 64'd0);
    chk("t5_count", 64'(cnt_b), 64'd0);
    valid_b = 1'b0;
    cycle("t5");
    chk("t5_drop_end", 64'(drop_b), 64'd0);

    // Reset mid-operation with ports 0 and 3 half full
    rin_a = '0;
    for (int k = 0; k < 4; k++) begin
      din_a = 8'(8'h30 + k); addr_a = (k < 2) ? 2'd0 : 2'd3; valid_a = 1'b1;
      cycle("t6_fill");
    end
    chk("t6_half0", 64'(cnt_a[0 +: CW]), 64'd2);
    do_reset_mid();
    chk("t6_post_valid", 64'(vout_a), 64'd0);
    chk("t6_post_count", 64'(cnt_a), 64'd0);
    din_a = 8'hD0; addr_a = 2'd0; valid_a = 1'b1;
    cycle("t6_new");
    chk("t6_new_dout", 64'(dout_a[0 +: W]), 64'hD0);
    chk("t6_new_count", 64'(cnt_a[0 +: CW]), 64'd1);
    valid_a = 1'b0; rin_a = '1;
    repeat (2) cycle("t6_drain");

    // Randomised traffic on both instances, held words until accepted
    thr_a = 7; thr_b = 7;
    last_acc_a = 1'b0; last_acc_b = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        thr_a = $urandom_range(1, 10);
        thr_b = $urandom_range(1, 10);
      end
      if (n == 1500) do_reset_mid();
      if (!valid_a || last_acc_a) begin
        valid_a = ($urandom_range(0, 3) != 0);
        din_a = 8'($urandom);
        addr_a = 2'($urandom);
      end
      if (!valid_b || last_acc_b) begin
        valid_b = ($urandom_range(0, 3) != 0);
        din_b = 8'($urandom);
        addr_b = 2'($urandom);
      end
      for (int i = 0; i < NPA; i++) rin_a[i] = ($urandom_range(0, 9) < thr_a);
      for (int i = 0; i < NPB; i++) rin_b[i] = ($urandom_range(0, 9) < thr_b);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
